// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Framed host-command parser placed after the UART receiver.
//            Frame = SYNC, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN
//            and payload). Valid frames are strobed out with opcode/payload.
//            Opcodes 0x01/0x02 set/clear the pause_req level.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int                   DATA_BIT       = 8,
    parameter int                   MAX_PAYLOAD    = 4,
    parameter int                   TIMEOUT_CYCLES = 100000,
    parameter logic [DATA_BIT-1:0]  SYNC_BYTE      = 8'h55
) (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic [DATA_BIT-1:0]         rx_data,
    input  logic                        rx_data_valid,
    output logic                        cmd_valid,
    output logic [DATA_BIT-1:0]         cmd_code,
    output logic [3:0]                  cmd_len,
    output logic [8*MAX_PAYLOAD-1:0]    cmd_payload,
    output logic                        pause_req,
    output logic                        frame_error,
    output logic [1:0]                  err_code
);

    localparam int                  PAY_W    = 8 * MAX_PAYLOAD;
    localparam int                  CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_BIT-1:0] MAX_LEN  = DATA_BIT'(MAX_PAYLOAD);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] S_CMD = 3'd1;
    localparam logic [2:0] S_LEN = 3'd2;
    localparam logic [2:0] S_PAY = 3'd3;
    localparam logic [2:0] S_CHK = 3'd4;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    // Frame-in-progress state
    logic [2:0]             state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BIT-1:0]    xor_q, xor_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BIT-1:0]    code_q, code_d;
    logic [3:0]             len_q, len_d;
    logic [PAY_W-1:0]       pay_q, pay_d;

    // Registered outputs
    logic                   cmd_valid_q, cmd_valid_d;
    logic [DATA_BIT-1:0]    cmd_code_q, cmd_code_d;
    logic [3:0]             cmd_len_q, cmd_len_d;
    logic [PAY_W-1:0]       cmd_payload_q, cmd_payload_d;
    logic                   pause_q, pause_d;
    logic                   frame_error_q, frame_error_d;
    logic [1:0]             err_code_q, err_code_d;

    // Next-state logic: timeout has priority over any byte on the same cycle
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        xor_d         = xor_q;
        cnt_d         = cnt_q;
        code_d        = code_q;
        len_d         = len_q;
        pay_d         = pay_q;
        cmd_valid_d   = 1'b0;
        cmd_code_d    = cmd_code_q;
        cmd_len_d     = cmd_len_q;
        cmd_payload_d = cmd_payload_q;
        pause_d       = pause_q;
        frame_error_d = 1'b0;
        err_code_d    = err_code_q;

        if ((state_q != IDLE) && (cnt_q == TMO_LAST)) begin
            state_d       = IDLE;
            cnt_d         = '0;
            idx_d         = '0;
            frame_error_d = 1'b1;
            err_code_d    = ERR_TMO;
        end else begin
            // Counter only runs mid-frame and restarts on every accepted byte
            if ((state_q == IDLE) || rx_data_valid) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (rx_data_valid) begin
                case (state_q)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_d = S_CMD;
                        end
                    end
                    S_CMD: begin
                        code_d  = rx_data;
                        xor_d   = rx_data;
                        state_d = S_LEN;
                    end
                    S_LEN: begin
                        if (rx_data > MAX_LEN) begin
                            frame_error_d = 1'b1;
                            err_code_d    = ERR_LEN;
                            state_d       = IDLE;
                        end else begin
                            len_d   = rx_data[3:0];
                            xor_d   = xor_q ^ rx_data;
                            idx_d   = '0;
                            // Clearing here leaves bytes beyond LEN at zero
                            pay_d   = '0;
                            state_d = (rx_data == '0) ? S_CHK : S_PAY;
                        end
                    end
                    S_PAY: begin
                        for (int i = 0; i < MAX_PAYLOAD; i++) begin
                            if (idx_q == i[3:0]) begin
                                pay_d[i*8 +: 8] = rx_data;
                            end
                        end
                        xor_d = xor_q ^ rx_data;
                        idx_d = idx_q + 4'd1;
                        if ((idx_q + 4'd1) == len_q) begin
                            state_d = S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (rx_data == xor_q) begin
                            cmd_valid_d   = 1'b1;
                            cmd_code_d    = code_q;
                            cmd_len_d     = len_q;
                            cmd_payload_d = pay_q;
                            if (code_q == 8'h01) begin
                                pause_d = 1'b1;
                            end else if (code_q == 8'h02) begin
                                pause_d = 1'b0;
                            end
                        end else begin
                            frame_error_d = 1'b1;
                            err_code_d    = ERR_CHK;
                        end
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset aborts any frame without a strobe
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            xor_q         <= '0;
            cnt_q         <= '0;
            code_q        <= '0;
            len_q         <= '0;
            pay_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            pause_q       <= 1'b0;
            frame_error_q <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            xor_q         <= xor_d;
            cnt_q         <= cnt_d;
            code_q        <= code_d;
            len_q         <= len_d;
            pay_q         <= pay_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            cmd_len_q     <= cmd_len_d;
            cmd_payload_q <= cmd_payload_d;
            pause_q       <= pause_d;
            frame_error_q <= frame_error_d;
            err_code_q    <= err_code_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign cmd_len     = cmd_len_q;
    assign cmd_payload = cmd_payload_q;
    assign pause_req   = pause_q;
    assign frame_error = frame_error_q;
    assign err_code    = err_code_q;

endmodule
`default_nettype wire
